// File: rtl/wb_mem_responder.sv
// Wishbone data-bus responder: word RAM with byte lanes, wait states and a console byte FIFO.
// Optional WB_MEM_RESPONDER_ERR_EN adds err responses for addresses beyond the RAM.
module wb_mem_responder #(
    parameter int          P_ADDR_BITS       = 14,
    parameter int          P_WAIT_STATES     = 0,
    parameter logic [31:0] P_CONSOLE_ADDR    = 32'h1000_0000,
    parameter int          P_FIFO_DEPTH_LOG2 = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_sync,
    input  logic        i_read_stb,
    output logic        o_read_ack,
    input  logic [31:0] i_read_addr,
    output logic [31:0] o_read_data,
    input  logic        i_write_stb,
    output logic        o_write_ack,
    input  logic [31:0] i_write_addr,
    input  logic [31:0] i_write_data,
    input  logic [3:0]  i_write_sel,
    output logic        o_console_valid,
    output logic [7:0]  o_console_data,
    input  logic        i_console_ready
`ifdef WB_MEM_RESPONDER_ERR_EN
    ,
    output logic        o_read_err,
    output logic        o_write_err
`endif
);

    // state   | meaning
    // ST_IDLE | waiting for a strobe
    // ST_WAIT | wait-state countdown, or console write held by a full FIFO
    // ST_ACK  | one-cycle ack (or err) pulse
    typedef enum logic [1:0] { ST_IDLE, ST_WAIT, ST_ACK } state_t;

    localparam int             LP_RAM_DEPTH  = 2 ** P_ADDR_BITS;
    localparam int             LP_FW         = P_FIFO_DEPTH_LOG2;
    localparam int             LP_FIFO_DEPTH = 2 ** P_FIFO_DEPTH_LOG2;
    localparam logic [3:0]     LP_WAIT       = 4'(P_WAIT_STATES);
    localparam logic [LP_FW:0] LP_FIFO_FULL  = (LP_FW + 1)'(LP_FIFO_DEPTH);

    logic [31:0] ram_q  [LP_RAM_DEPTH];
    logic [7:0]  fifo_q [LP_FIFO_DEPTH];

    state_t      rd_state_q, rd_state_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] rd_addr_cur;
    logic        rd_enter_ack, rd_bad_cur, rd_bad_lat;

    state_t      wr_state_q, wr_state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [3:0]  wr_sel_q, wr_sel_d;
    logic [31:0] wr_addr_cur, wr_data_cur;
    logic [3:0]  wr_sel_cur;
    logic        wr_enter_ack, wr_bad_cur, wr_bad_lat, wr_is_con, wr_blocked;
    logic        ram_we;

    logic [LP_FW-1:0] fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [LP_FW-1:0] fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [LP_FW:0]   fifo_cnt_q, fifo_cnt_d;
    logic             fifo_push, fifo_pop, fifo_full;

    // On the accept cycle the bus inputs are live; afterwards the latched copy is used.
    assign rd_addr_cur = (rd_state_q == ST_IDLE) ? i_read_addr  : rd_addr_q;
    assign wr_addr_cur = (wr_state_q == ST_IDLE) ? i_write_addr : wr_addr_q;
    assign wr_data_cur = (wr_state_q == ST_IDLE) ? i_write_data : wr_data_q;
    assign wr_sel_cur  = (wr_state_q == ST_IDLE) ? i_write_sel  : wr_sel_q;

`ifdef WB_MEM_RESPONDER_ERR_EN
    function automatic logic addr_bad(input logic [31:0] a);
        return ((a >> (P_ADDR_BITS + 2)) != 32'd0) && (a != P_CONSOLE_ADDR);
    endfunction

    assign rd_bad_cur  = addr_bad(rd_addr_cur);
    assign rd_bad_lat  = addr_bad(rd_addr_q);
    assign wr_bad_cur  = addr_bad(wr_addr_cur);
    assign wr_bad_lat  = addr_bad(wr_addr_q);
    assign o_read_err  = (rd_state_q == ST_ACK) && rd_bad_lat;
    assign o_write_err = (wr_state_q == ST_ACK) && wr_bad_lat;
`else
    assign rd_bad_cur = 1'b0;
    assign rd_bad_lat = 1'b0;
    assign wr_bad_cur = 1'b0;
    assign wr_bad_lat = 1'b0;
`endif

    assign o_read_ack  = (rd_state_q == ST_ACK) && !rd_bad_lat;
    assign o_write_ack = (wr_state_q == ST_ACK) && !wr_bad_lat;
    assign o_read_data = rd_data_q;

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_cnt_d     = rd_cnt_q;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = 32'h0;
        rd_enter_ack = 1'b0;
        case (rd_state_q)
            ST_IDLE: begin
                if (i_read_stb && !o_read_ack) begin
                    rd_addr_d = i_read_addr;
                    rd_cnt_d  = LP_WAIT;
                    if (LP_WAIT == 4'd0) begin
                        rd_state_d   = ST_ACK;
                        rd_enter_ack = 1'b1;
                    end else begin
                        rd_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                rd_cnt_d = rd_cnt_q - 4'd1;
                if (rd_cnt_q == 4'd1) begin
                    rd_state_d   = ST_ACK;
                    rd_enter_ack = 1'b1;
                end
            end
            ST_ACK:  rd_state_d = ST_IDLE;
            default: rd_state_d = ST_IDLE;
        endcase
        // Sampled before this edge's RAM write lands, so a colliding write is not seen.
        if (rd_enter_ack && !rd_bad_cur && (rd_addr_cur != P_CONSOLE_ADDR)) begin
            rd_data_d = ram_q[rd_addr_cur[P_ADDR_BITS+1:2]];
        end
    end

    assign wr_is_con  = (wr_addr_cur == P_CONSOLE_ADDR);
    assign wr_blocked = wr_is_con && fifo_full && !fifo_pop;

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_cnt_d     = wr_cnt_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_sel_d     = wr_sel_q;
        wr_enter_ack = 1'b0;
        case (wr_state_q)
            ST_IDLE: begin
                if (i_write_stb && !o_write_ack) begin
                    wr_addr_d = i_write_addr;
                    wr_data_d = i_write_data;
                    wr_sel_d  = i_write_sel;
                    wr_cnt_d  = LP_WAIT;
                    if ((LP_WAIT == 4'd0) && !wr_blocked) begin
                        wr_state_d   = ST_ACK;
                        wr_enter_ack = 1'b1;
                    end else begin
                        wr_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wr_cnt_q > 4'd1) begin
                    wr_cnt_d = wr_cnt_q - 4'd1;
                end else begin
                    wr_cnt_d = 4'd0;
                    if (!wr_blocked) begin
                        wr_state_d   = ST_ACK;
                        wr_enter_ack = 1'b1;
                    end
                end
            end
            ST_ACK:  wr_state_d = ST_IDLE;
            default: wr_state_d = ST_IDLE;
        endcase
    end

    assign ram_we    = wr_enter_ack && !wr_is_con && !wr_bad_cur && !i_reset_sync;
    assign fifo_push = wr_enter_ack && wr_is_con && !i_reset_sync;
    assign fifo_pop  = (fifo_cnt_q != '0) && i_console_ready;
    assign fifo_full = (fifo_cnt_q == LP_FIFO_FULL);

    always_comb begin
        fifo_wr_ptr_d = fifo_push ? fifo_wr_ptr_q + 1'b1 : fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_pop  ? fifo_rd_ptr_q + 1'b1 : fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q + (LP_FW + 1)'(fifo_push) - (LP_FW + 1)'(fifo_pop);
    end

    assign o_console_valid = (fifo_cnt_q != '0);
    assign o_console_data  = o_console_valid ? fifo_q[fifo_rd_ptr_q] : 8'h00;

    always_ff @(posedge i_clk) begin
        if (i_reset_sync) begin
            rd_state_q    <= ST_IDLE;
            rd_cnt_q      <= 4'd0;
            rd_addr_q     <= 32'h0;
            rd_data_q     <= 32'h0;
            wr_state_q    <= ST_IDLE;
            wr_cnt_q      <= 4'd0;
            wr_addr_q     <= 32'h0;
            wr_data_q     <= 32'h0;
            wr_sel_q      <= 4'h0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            rd_state_q    <= rd_state_d;
            rd_cnt_q      <= rd_cnt_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            wr_state_q    <= wr_state_d;
            wr_cnt_q      <= wr_cnt_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_sel_q      <= wr_sel_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel_cur[b]) ram_q[wr_addr_cur[P_ADDR_BITS+1:2]][8*b +: 8] <= wr_data_cur[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_push) fifo_q[fifo_wr_ptr_q] <= wr_data_cur[7:0];
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: two instances (0 and 3 wait states) checked against a word-array model.
module tb_wb_mem_responder;

    localparam int          AB  = 14;
    localparam logic [31:0] CON = 32'h1000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       rs, rack, ws, wack, cv, cr, rerr, werr;
    logic [1:0][31:0] raddr, rdata, waddr, wdata;
    logic [1:0][3:0]  wsel;
    logic [1:0][7:0]  cd;

    int checks   = 0;
    int failures = 0;
    bit [31:0] mdl [int];

    wb_mem_responder #(.P_ADDR_BITS(AB), .P_WAIT_STATES(0), .P_CONSOLE_ADDR(CON), .P_FIFO_DEPTH_LOG2(3)) dut0 (
        .i_clk(clk), .i_reset_sync(rst[0]),
        .i_read_stb(rs[0]), .o_read_ack(rack[0]), .i_read_addr(raddr[0]), .o_read_data(rdata[0]),
        .i_write_stb(ws[0]), .o_write_ack(wack[0]), .i_write_addr(waddr[0]), .i_write_data(wdata[0]),
        .i_write_sel(wsel[0]), .o_console_valid(cv[0]), .o_console_data(cd[0]), .i_console_ready(cr[0])
`ifdef WB_MEM_RESPONDER_ERR_EN
        , .o_read_err(rerr[0]), .o_write_err(werr[0])
`endif
    );

    wb_mem_responder #(.P_ADDR_BITS(AB), .P_WAIT_STATES(3), .P_CONSOLE_ADDR(CON), .P_FIFO_DEPTH_LOG2(3)) dut1 (
        .i_clk(clk), .i_reset_sync(rst[1]),
        .i_read_stb(rs[1]), .o_read_ack(rack[1]), .i_read_addr(raddr[1]), .o_read_data(rdata[1]),
        .i_write_stb(ws[1]), .o_write_ack(wack[1]), .i_write_addr(waddr[1]), .i_write_data(wdata[1]),
        .i_write_sel(wsel[1]), .o_console_valid(cv[1]), .o_console_data(cd[1]), .i_console_ready(cr[1])
`ifdef WB_MEM_RESPONDER_ERR_EN
        , .o_read_err(rerr[1]), .o_write_err(werr[1])
`endif
    );

`ifndef WB_MEM_RESPONDER_ERR_EN
    assign rerr = 2'b00;
    assign werr = 2'b00;
`endif

    function automatic int exp_lat(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic int mkey(input int u, input logic [31:0] a);
        return u * 65536 + int'(a[AB+1:2]);
    endfunction

    function automatic void mdl_write(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit [31:0] w;
        if (a == CON) return;
        w = mdl.exists(mkey(u, a)) ? mdl[mkey(u, a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[mkey(u, a)] = w;
    endfunction

    function automatic logic [31:0] mdl_read(input int u, input logic [31:0] a);
        if (a == CON) return 32'h0;
        return mdl.exists(mkey(u, a)) ? mdl[mkey(u, a)] : 32'h0;
    endfunction

    // st = {err, ack} seen at the response; 2'b00 means no response within the bound.
    task automatic tx_read(input int u, input logic [31:0] a, output logic [31:0] d, output int lat, output logic [1:0] st);
        @(posedge clk); #1;
        rs[u] = 1'b1; raddr[u] = a; st = 2'b00; lat = -1; d = 32'h0;
        for (int i = 0; i < 64 && st == 2'b00; i++) begin
            @(negedge clk);
            if (rack[u] || rerr[u]) begin st = {rerr[u], rack[u]}; lat = i; d = rdata[u]; end
        end
        @(posedge clk); #1;
        rs[u] = 1'b0;
    endtask

    task automatic tx_write(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int lat, output logic [1:0] st);
        @(posedge clk); #1;
        ws[u] = 1'b1; waddr[u] = a; wdata[u] = d; wsel[u] = s; st = 2'b00; lat = -1;
        for (int i = 0; i < 64 && st == 2'b00; i++) begin
            @(negedge clk);
            if (wack[u] || werr[u]) begin st = {werr[u], wack[u]}; lat = i; end
        end
        @(posedge clk); #1;
        ws[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (rack[u] !== 1'b0 || wack[u] !== 1'b0 || rdata[u] !== 32'h0) begin
                failures++;
                $display("FAIL reset_bus u=%0d got rack=%b wack=%b rdata=%h want 0 0 0", u, rack[u], wack[u], rdata[u]);
            end
            checks++;
            if (cv[u] !== 1'b0 || cd[u] !== 8'h00) begin
                failures++;
                $display("FAIL reset_console u=%0d got valid=%b data=%h want 0 00", u, cv[u], cd[u]);
            end
        end
    endtask

    task automatic test_read_latency();
        logic [31:0] d; int lat; logic [1:0] st;
        tx_write(0, 32'h10, 32'hCAFE_F00D, 4'hF, lat, st);
        mdl_write(0, 32'h10, 32'hCAFE_F00D, 4'hF);
        checks++;
        if (st !== 2'b01 || lat != 1) begin
            failures++; $display("FAIL wr_latency got st=%b lat=%0d want st=01 lat=1", st, lat);
        end
        tx_read(0, 32'h10, d, lat, st);
        checks++;
        if (st !== 2'b01 || lat != 1 || d !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL rd_latency got st=%b lat=%0d data=%h want st=01 lat=1 data=cafef00d", st, lat, d);
        end
        @(negedge clk);
        checks++;
        if (rack[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            failures++; $display("FAIL rd_single_pulse got ack=%b data=%h want ack=0 data=0", rack[0], rdata[0]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d; int lat; logic [1:0] st;
        tx_write(0, 32'h20, 32'h1122_3344, 4'hF, lat, st);
        tx_write(0, 32'h20, 32'hAABB_CCDD, 4'b0101, lat, st);
        tx_read(0, 32'h20, d, lat, st);
        checks++;
        if (st !== 2'b01 || d !== 32'h11BB_33DD) begin
            failures++; $display("FAIL byte_lanes got st=%b data=%h want st=01 data=11bb33dd", st, d);
        end
        tx_write(0, 32'h20, 32'hFFFF_FFFF, 4'b0000, lat, st);
        tx_read(0, 32'h20, d, lat, st);
        checks++;
        if (st !== 2'b01 || d !== 32'h11BB_33DD) begin
            failures++; $display("FAIL sel_none got st=%b data=%h want st=01 data=11bb33dd", st, d);
        end
        mdl_write(0, 32'h20, 32'h11BB_33DD, 4'hF);
    endtask

    task automatic test_wait_states();
        logic [31:0] d, v; int lat; logic [1:0] st; int ack_cyc[$]; int nb;
        v = $urandom;
        tx_write(1, 32'h200, v, 4'hF, lat, st);
        mdl_write(1, 32'h200, v, 4'hF);
        checks++;
        if (st !== 2'b01 || lat != 4) begin
            failures++; $display("FAIL ws_wr_latency got st=%b lat=%0d want st=01 lat=4", st, lat);
        end
        tx_read(1, 32'h200, d, lat, st);
        checks++;
        if (st !== 2'b01 || lat != 4 || d !== v) begin
            failures++; $display("FAIL ws_rd_latency got st=%b lat=%0d data=%h want st=01 lat=4 data=%h", st, lat, d, v);
        end
        @(posedge clk); #1;
        rs[1] = 1'b1; raddr[1] = 32'h200; nb = 0;
        for (int i = 0; i < 40 && ack_cyc.size() < 3; i++) begin
            @(negedge clk);
            if (rack[1]) begin
                ack_cyc.push_back(i);
                if (rdata[1] !== v) nb++;
            end
        end
        @(posedge clk); #1;
        rs[1] = 1'b0;
        checks++;
        if (ack_cyc.size() != 3 || ack_cyc[0] != 4 || ack_cyc[1] - ack_cyc[0] != 5 || ack_cyc[2] - ack_cyc[1] != 5 || nb != 0) begin
            failures++;
            $display("FAIL back_to_back got acks=%p bad_data=%0d want acks at 4,9,14 bad_data=0", ack_cyc, nb);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, got, want; logic [3:0] s; int lat, u; logic [1:0] st;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                d = $urandom;
                tx_write(k, 32'h100 + 32'(i * 4), d, 4'hF, lat, st);
                mdl_write(k, 32'h100 + 32'(i * 4), d, 4'hF);
            end
        end
        for (int n = 0; n < 120; n++) begin
            u = $urandom_range(0, 1);
            a = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
`ifndef WB_MEM_RESPONDER_ERR_EN
            a[31:16] = 16'($urandom);
`endif
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom);
                tx_write(u, a, d, s, lat, st);
                mdl_write(u, a, d, s);
                checks++;
                if (st !== 2'b01 || lat != exp_lat(u)) begin
                    failures++;
                    $display("FAIL rand_write u=%0d addr=%h got st=%b lat=%0d want st=01 lat=%0d", u, a, st, lat, exp_lat(u));
                end
            end else begin
                want = mdl_read(u, a);
                tx_read(u, a, got, lat, st);
                checks++;
                if (st !== 2'b01 || lat != exp_lat(u) || got !== want) begin
                    failures++;
                    $display("FAIL rand_read u=%0d addr=%h got st=%b lat=%0d data=%h want st=01 lat=%0d data=%h",
                             u, a, st, lat, got, exp_lat(u), want);
                end
            end
        end
    endtask

    task automatic test_read_before_write();
        logic [31:0] v0, v1, d; int lr, lw; logic [1:0] sr, sw;
        for (int u = 0; u < 2; u++) begin
            v0 = $urandom; v1 = ~v0;
            tx_write(u, 32'h60, v0, 4'hF, lw, sw);
            mdl_write(u, 32'h60, v0, 4'hF);
            fork
                tx_read(u, 32'h60, d, lr, sr);
                tx_write(u, 32'h60, v1, 4'hF, lw, sw);
            join
            mdl_write(u, 32'h60, v1, 4'hF);
            checks++;
            if (sr !== 2'b01 || sw !== 2'b01 || lr != lw || d !== v0) begin
                failures++;
                $display("FAIL rd_before_wr u=%0d got data=%h lat r/w=%0d/%0d want data=%h equal lats", u, d, lr, lw, v0);
            end
            tx_read(u, 32'h60, d, lr, sr);
            checks++;
            if (sr !== 2'b01 || d !== v1) begin
                failures++; $display("FAIL rd_after_wr u=%0d got data=%h want %h", u, d, v1);
            end
        end
    endtask

    task automatic test_console();
        logic [31:0] d; int lat, bad; logic [1:0] st;
        cr[0] = 1'b0;
        tx_write(0, 32'h0, 32'h0102_0304, 4'hF, lat, st);
        mdl_write(0, 32'h0, 32'h0102_0304, 4'hF);
        bad = 0;
        tx_write(0, CON, 32'hDEAD_BE48, 4'($urandom), lat, st);
        if (st !== 2'b01 || lat != 1) bad++;
        tx_write(0, CON, 32'h1234_5669, 4'b0000, lat, st);
        if (st !== 2'b01 || lat != 1) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL console_ack got bad_acks=%0d want 0", bad);
        end
        @(negedge clk);
        checks++;
        if (cv[0] !== 1'b1 || cd[0] !== 8'h48) begin
            failures++; $display("FAIL console_head got valid=%b data=%h want 1 48", cv[0], cd[0]);
        end
        @(posedge clk); #1 cr[0] = 1'b1;
        @(posedge clk); #1 cr[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (cv[0] !== 1'b1 || cd[0] !== 8'h69) begin
            failures++; $display("FAIL console_second got valid=%b data=%h want 1 69", cv[0], cd[0]);
        end
        @(posedge clk); #1 cr[0] = 1'b1;
        @(posedge clk); #1 cr[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (cv[0] !== 1'b0 || cd[0] !== 8'h00) begin
            failures++; $display("FAIL console_empty got valid=%b data=%h want 0 00", cv[0], cd[0]);
        end
        tx_read(0, 32'h0, d, lat, st);
        checks++;
        if (st !== 2'b01 || d !== 32'h0102_0304) begin
            failures++; $display("FAIL console_ram_untouched got st=%b data=%h want st=01 data=01020304", st, d);
        end
        tx_read(0, CON, d, lat, st);
        checks++;
        if (st !== 2'b01 || lat != 1 || d !== 32'h0) begin
            failures++; $display("FAIL console_read got st=%b lat=%0d data=%h want st=01 lat=1 data=0", st, lat, d);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] b [9]; int lat, bad, early; logic [1:0] st;
        cr[0] = 1'b0; bad = 0; early = 0;
        for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            tx_write(0, CON, {24'($urandom), b[i]}, 4'hF, lat, st);
            if (st !== 2'b01 || lat != 1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL fifo_fill got bad_acks=%0d want 0", bad);
        end
        @(posedge clk); #1;
        ws[0] = 1'b1; waddr[0] = CON; wdata[0] = {24'h0, b[8]}; wsel[0] = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wack[0]) early++;
        end
        checks++;
        if (early != 0 || cd[0] !== b[0]) begin
            failures++; $display("FAIL fifo_backpressure got early_acks=%0d head=%h want 0 head=%h", early, cd[0], b[0]);
        end
        @(posedge clk); #1 cr[0] = 1'b1;
        @(posedge clk); #1 cr[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (wack[0] !== 1'b1) begin
            failures++; $display("FAIL fifo_release_ack got ack=%b want 1", wack[0]);
        end
        @(posedge clk); #1 ws[0] = 1'b0; cr[0] = 1'b1;
        bad = 0;
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            if (cv[0] !== 1'b1 || cd[0] !== b[k]) begin
                bad++;
                $display("FAIL fifo_order idx=%0d got valid=%b data=%h want 1 %h", k, cv[0], cd[0], b[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (bad != 0 || cv[0] !== 1'b0) begin
            failures++; $display("FAIL fifo_drain got bad=%0d valid_after=%b want 0 0", bad, cv[0]);
        end
        @(posedge clk); #1 cr[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int lat, acks; logic [1:0] st;
        cr[1] = 1'b0;
        tx_write(1, 32'h180, 32'h5A5A_5A5A, 4'hF, lat, st);
        mdl_write(1, 32'h180, 32'h5A5A_5A5A, 4'hF);
        @(posedge clk); #1;
        ws[1] = 1'b1; waddr[1] = 32'h180; wdata[1] = 32'hFFFF_FFFF; wsel[1] = 4'hF;
        @(posedge clk); #1 rst[1] = 1'b1; ws[1] = 1'b0;
        @(posedge clk); #1 rst[1] = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wack[1] || werr[1]) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++; $display("FAIL reset_abort_ack got acks=%0d want 0", acks);
        end
        tx_read(1, 32'h180, d, lat, st);
        checks++;
        if (st !== 2'b01 || d !== mdl_read(1, 32'h180)) begin
            failures++; $display("FAIL reset_abort_ram got st=%b data=%h want st=01 data=%h", st, d, mdl_read(1, 32'h180));
        end
        tx_write(1, CON, 32'h41, 4'hF, lat, st);
        tx_write(1, CON, 32'h42, 4'hF, lat, st);
        @(posedge clk); #1;
        ws[1] = 1'b1; waddr[1] = CON; wdata[1] = 32'h43;
        @(posedge clk); #1 rst[1] = 1'b1; ws[1] = 1'b0;
        @(posedge clk); #1 rst[1] = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wack[1] || cv[1]) acks++;
        end
        checks++;
        if (acks != 0 || cd[1] !== 8'h00) begin
            failures++; $display("FAIL reset_fifo_flush got busy_cycles=%0d data=%h want 0 00", acks, cd[1]);
        end
    endtask

`ifdef WB_MEM_RESPONDER_ERR_EN
    task automatic test_err();
        logic [31:0] d, v; int lat; logic [1:0] st;
        v = $urandom;
        tx_write(0, 32'h40, v, 4'hF, lat, st);
        mdl_write(0, 32'h40, v, 4'hF);
        tx_read(0, 32'h0010_0000, d, lat, st);
        checks++;
        if (st !== 2'b10 || lat != 1 || d !== 32'h0) begin
            failures++; $display("FAIL err_read got st=%b lat=%0d data=%h want st=10 lat=1 data=0", st, lat, d);
        end
        tx_write(0, 32'h0010_0040, ~v, 4'hF, lat, st);
        checks++;
        if (st !== 2'b10 || lat != 1) begin
            failures++; $display("FAIL err_write got st=%b lat=%0d want st=10 lat=1", st, lat);
        end
        tx_read(0, 32'h40, d, lat, st);
        checks++;
        if (st !== 2'b01 || d !== v) begin
            failures++; $display("FAIL err_write_ram got st=%b data=%h want st=01 data=%h", st, d, v);
        end
    endtask
`endif

    initial begin
        rst = 2'b11; rs = '0; ws = '0; cr = '0;
        raddr = '0; waddr = '0; wdata = '0; wsel = '0;
        test_reset();
        test_read_latency();
        test_byte_lanes();
        test_wait_states();
        test_random();
        test_read_before_write();
        test_console();
        test_fifo_full();
        test_reset_mid();
`ifdef WB_MEM_RESPONDER_ERR_EN
        test_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout at %0t want completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
